// File: rtl/cnn_conv_act.sv
// cnn_conv_act: per-lane activation (bypass / ReLU / ReLU6 / leaky) plus a count of zero output lanes.
// Latency: 2 cycles from input handshake to valid_out; full throughput of 1 beat per cycle.
// Backpressure: out_ready stalls stage 2; in_ready drops combinationally only when both stages hold beats.
module cnn_conv_act #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in,
  input  logic [1:0]                    mode,
  output logic [LANES*DATA_WIDTH-1:0]   out,
  output logic                          valid_out,
  input  logic                          out_ready,
  output logic [$clog2(LANES+1)-1:0]    zero_cnt
);

  localparam int ZW = $clog2(LANES+1);
  localparam logic signed [DATA_WIDTH-1:0] RELU6_MAX = DATA_WIDTH'(6 << FRAC_BITS);

  logic                          s1_vld;
  logic                          s2_vld;
  logic                          s1_en;
  logic                          s2_en;
  logic [LANES*DATA_WIDTH-1:0]   s1_dat;
  logic [1:0]                    s1_mode;
  logic [LANES*DATA_WIDTH-1:0]   act_dat;
  logic [ZW-1:0]                 act_zc;
  logic signed [DATA_WIDTH-1:0]  lane_v;
  logic signed [DATA_WIDTH-1:0]  res_v;

  assign s2_en     = out_ready | ~s2_vld;
  assign s1_en     = s2_en | ~s1_vld;
  assign in_ready  = s1_en;
  assign valid_out = s2_vld;

  always_comb begin
    act_dat = '0;
    act_zc  = '0;
    lane_v  = '0;
    res_v   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_v = s1_dat[k*DATA_WIDTH +: DATA_WIDTH];
      case (s1_mode)
        2'd1: res_v = lane_v[DATA_WIDTH-1] ? '0 : lane_v;
        2'd2: begin
          if (lane_v[DATA_WIDTH-1])
            res_v = '0;
          else if (lane_v > RELU6_MAX)
            res_v = RELU6_MAX;
          else
            res_v = lane_v;
        end
        // Arithmetic shift floors toward -inf and cannot overflow, even for the most negative lane.
        2'd3: res_v = lane_v[DATA_WIDTH-1] ? (lane_v >>> LEAKY_SHIFT) : lane_v;
        default: res_v = lane_v;
      endcase
      act_dat[k*DATA_WIDTH +: DATA_WIDTH] = res_v;
      if (res_v == '0)
        act_zc = act_zc + ZW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld   <= 1'b0;
      s1_dat   <= '0;
      s1_mode  <= '0;
      s2_vld   <= 1'b0;
      out      <= '0;
      zero_cnt <= '0;
    end else begin
      if (s1_en) begin
        s1_vld <= valid_in;
        if (valid_in) begin
          s1_dat  <= in;
          s1_mode <= mode;
        end
      end
      if (s2_en) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          out      <= act_dat;
          zero_cnt <= act_zc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_act.sv
// Bench for cnn_conv_act: directed activation vectors, random streams under backpressure, mid-flight reset.
module tb_cnn_conv_act;

  localparam int DW   = 16;
  localparam int LN   = 4;
  localparam int FRAC = 8;
  localparam int LS   = 3;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  z;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_b = '0;
  logic [1:0]  mode = '0;
  logic        in_ready;
  logic [63:0] out_b;
  logic        valid_out;
  logic [2:0]  zero_cnt;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_out = 0;
  beat_t exp_q[$];
  logic        stall_prev = 1'b0;
  logic [63:0] prev_out = '0;
  logic [2:0]  prev_zc = '0;
  logic        last_in_hs = 1'b0;

  cnn_conv_act #(
    .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .LANES(LN), .LEAKY_SHIFT(LS)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_ready(in_ready),
    .in(in_b), .mode(mode), .out(out_b), .valid_out(valid_out),
    .out_ready(out_ready), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference activation on plain integers: floor division models the leaky slope.
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input logic [1:0] m);
    int v;
    v = int'($signed(x));
    case (m)
      2'd1: if (v < 0) v = 0;
      2'd2: begin
        if (v < 0) v = 0;
        else if (v > 6 * (1 << FRAC)) v = 6 * (1 << FRAC);
      end
      2'd3: if (v < 0) v = -((-v + (1 << LS) - 1) / (1 << LS));
      default: ;
    endcase
    return 16'(v);
  endfunction

  function automatic beat_t ref_beat(input logic [63:0] d, input logic [1:0] m);
    beat_t b;
    b = '0;
    for (int k = 0; k < LN; k++) begin
      b.d[k*DW +: DW] = ref_lane(d[k*DW +: DW], m);
      if (b.d[k*DW +: DW] == 16'h0) b.z = b.z + 3'd1;
    end
    return b;
  endfunction

  function automatic logic [63:0] rand_beat();
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < LN; k++) begin
      case ($urandom_range(0, 9))
        0: d[k*DW +: DW] = 16'h8000;
        1: d[k*DW +: DW] = 16'h7FFF;
        2: d[k*DW +: DW] = 16'h0600;
        3: d[k*DW +: DW] = 16'h0601;
        4: d[k*DW +: DW] = 16'h0000;
        5: d[k*DW +: DW] = 16'hFFFF;
        default: d[k*DW +: DW] = 16'($urandom);
      endcase
    end
    return d;
  endfunction

  // One cycle: drive at negedge, sample 1 time unit later, then model the coming edge.
  task automatic step(input logic vi, input logic [63:0] d, input logic [1:0] m, input logic ordy);
    logic in_hs;
    logic out_hs;
    @(negedge clk);
    valid_in  = vi;
    in_b      = d;
    mode      = m;
    out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !ordy)));
    if (stall_prev) begin
      check("stall_valid", 64'(valid_out), 64'd1);
      check("stall_out", out_b, prev_out);
      check("stall_zc", 64'(zero_cnt), 64'(prev_zc));
    end
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        check("no_stale_beat", 64'(valid_out), 64'd0);
      end else begin
        check("out_data", out_b, exp_q[0].d);
        check("out_zc", 64'(zero_cnt), 64'(exp_q[0].z));
      end
    end
    out_hs = valid_out && ordy;
    in_hs  = vi && in_ready;
    if (out_hs) begin
      n_out++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (in_hs) exp_q.push_back(ref_beat(d, m));
    last_in_hs = in_hs;
    stall_prev = valid_out && !ordy;
    prev_out   = out_b;
    prev_zc    = zero_cnt;
  endtask

  task automatic directed(input string tag, input logic [63:0] d, input logic [1:0] m,
                          input logic [63:0] exp_d, input logic [2:0] exp_z);
    step(1'b1, d, m, 1'b1);
    step(1'b0, '0, 2'd0, 1'b1);
    check({tag, "_lat1_valid"}, 64'(valid_out), 64'd0);
    step(1'b0, '0, 2'd0, 1'b1);
    check({tag, "_lat2_valid"}, 64'(valid_out), 64'd1);
    check({tag, "_out"}, out_b, exp_d);
    check({tag, "_zc"}, 64'(zero_cnt), 64'(exp_z));
  endtask

  initial begin
    logic [63:0] exp41 [4];
    logic [63:0] cur;
    logic [1:0]  cur_m;
    logic        have;
    int          sent;
    int          out0;

    // Reset state, with inputs active to show they are ignored.
    valid_in  = 1'b1;
    in_b      = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_out", out_b, 64'd0);
    check("rst_zc", 64'(zero_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    directed("relu",   64'h0000_8000_0100_FF00, 2'd1, 64'h0000_0000_0100_0000, 3'd3);
    directed("relu6",  64'hF000_05FF_0600_0700, 2'd2, 64'h0000_05FF_0600_0600, 3'd1);
    directed("leaky",  64'h0123_FFFF_8000_FF00, 2'd3, 64'h0123_FFFF_F000_FFE0, 3'd0);

    // Back-to-back mode changes on identical lanes.
    exp41[0] = 64'hF800_F800_F800_F800;
    exp41[1] = 64'h0;
    exp41[2] = 64'h0;
    exp41[3] = 64'hFF00_FF00_FF00_FF00;
    for (int i = 0; i < 6; i++) begin
      step(i < 4, 64'hF800_F800_F800_F800, 2'(i), 1'b1);
      if (i >= 2) begin
        check("modeseq_valid", 64'(valid_out), 64'd1);
        check("modeseq_out", out_b, exp41[i-2]);
      end
    end

    // Eight-beat stream with random out_ready; each beat held until accepted.
    sent = 0;
    have = 1'b0;
    cur  = '0;
    cur_m = '0;
    out0 = n_out;
    for (int c = 0; c < 300 && (sent < 8 || exp_q.size() != 0); c++) begin
      if (sent < 8 && !have) begin
        cur   = rand_beat();
        cur_m = 2'($urandom_range(0, 3));
        have  = 1'b1;
      end
      step(sent < 8, cur, cur_m, 1'($urandom_range(0, 1)));
      if (last_in_hs) begin
        sent++;
        have = 1'b0;
      end
    end
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_delivered", 64'(n_out - out0), 64'd8);

    // Random soak with bursty valid_in and mostly-high out_ready.
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, rand_beat(), 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    for (int c = 0; c < 4; c++)
      step(1'b0, rand_beat(), 2'd0, 1'b1);
    check("soak_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight and downstream stalled.
    step(1'b1, 64'h0001_0002_0003_0004, 2'd0, 1'b0);
    step(1'b1, 64'h0005_0006_0007_0008, 2'd0, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0);
    check("pre_rst_valid", 64'(valid_out), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_out", out_b, 64'd0);
    check("midrst_zc", 64'(zero_cnt), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, '0, 2'd0, 1'b1);
      check("post_rst_idle", 64'(valid_out), 64'd0);
    end
    directed("post_rst", 64'h0100_FE00_0000_7FFF, 2'd2, 64'h0100_0000_0000_0600, 3'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
